// File: rtl/if_id_inst_queue_pkg.sv
// Shared constants for the fetch-to-decode instruction queue.
// Packet layout is {pc, inst}, 32 bits each.
package if_id_inst_queue_pkg;

   localparam int IF_TO_ID_BUS_SIZE = 64;
   localparam int IQ_DEPTH          = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } if_id_pkt_t;

endpackage : if_id_inst_queue_pkg

// File: rtl/if_id_inst_queue.sv
// Fetch-to-decode instruction FIFO: buffers {pc, inst} packets so a decode stall
// never loses SRAM read data, with valid/allow handshakes on both sides and flush.
module if_id_inst_queue
   import if_id_inst_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   parameter int BUS_W = IF_TO_ID_BUS_SIZE
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      in_valid,
   input  logic [BUS_W-1:0]          in_bus,
   output logic                      in_allow,
   output logic                      out_valid,
   output logic [BUS_W-1:0]          out_bus,
   input  logic                      out_allow,
   input  logic                      flush,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [BUS_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_push;
   logic w_pop;

   // in_allow looks only at registered occupancy, so a pop never frees a slot
   // for a push in the same cycle; this keeps out_allow off the fetch timing path.
   assign in_allow  = (r_count != FULL_CNT) & resetn;
   assign out_valid = (r_count != '0);
   assign out_bus   = r_mem[r_rd_ptr];
   assign count     = r_count;

   assign w_push = in_valid & in_allow  & ~flush;
   assign w_pop  = out_valid & out_allow & ~flush;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: the array is cleared on reset so out_bus reads zero until the first
   // push; flush leaves the data alone because out_valid already masks it.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= in_bus;
      end
   end

endmodule : if_id_inst_queue

// File: tb/tb_if_id_inst_queue.sv
// Self-checking bench for if_id_inst_queue: a directed vector table, hand-written
// corner sequences and random traffic, all compared against a queue-based model.
module tb_if_id_inst_queue;

   localparam int DEPTH = 4;
   localparam int BUS_W = 64;

   logic             clk = 1'b0;
   logic             resetn;
   logic             in_valid;
   logic [BUS_W-1:0] in_bus;
   logic             in_allow;
   logic             out_valid;
   logic [BUS_W-1:0] out_bus;
   logic             out_allow;
   logic             flush;
   logic [2:0]       count;

   int n_vec  = 0;
   int n_miss = 0;

   logic [63:0] mq[$];
   logic        m_allow;

   if_id_inst_queue #(.DEPTH(DEPTH), .BUS_W(BUS_W)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_bus    (in_bus),
      .in_allow  (in_allow),
      .out_valid (out_valid),
      .out_bus   (out_bus),
      .out_allow (out_allow),
      .flush     (flush),
      .count     (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rstn;
      logic        iv;
      logic [63:0] bus;
      logic        oa;
      logic        fl;
      logic        e_allow;
      logic        e_ovalid;
      logic [2:0]  e_count;
      logic        chk_bus;
      logic [63:0] e_bus;
   } vec_t;

   vec_t tbl[17];

   function automatic logic [63:0] pkt(input logic [31:0] pc, input logic [31:0] inst);
      return {pc, inst};
   endfunction

   function automatic vec_t mkv(input logic rstn, iv, input logic [63:0] bus,
                                input logic oa, fl, e_allow, e_ovalid,
                                input logic [2:0] e_count, input logic chk_bus,
                                input logic [63:0] e_bus);
      vec_t v;
      v.rstn = rstn; v.iv = iv; v.bus = bus; v.oa = oa; v.fl = fl;
      v.e_allow = e_allow; v.e_ovalid = e_ovalid; v.e_count = e_count;
      v.chk_bus = chk_bus; v.e_bus = e_bus;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle's inputs and move to the falling edge for sampling.
   task automatic apply(input logic rstn, iv, input logic [63:0] bus, input logic oa, fl);
      resetn = rstn; in_valid = iv; in_bus = bus; out_allow = oa; flush = fl;
      @(negedge clk);
   endtask

   task automatic model_check();
      m_allow = resetn && (mq.size() != DEPTH);
      check("in_allow",  {63'd0, in_allow},  {63'd0, m_allow});
      check("out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
      check("count",     {61'd0, count},     64'(mq.size()));
      if (mq.size() != 0) check("out_bus", out_bus, mq[0]);
   endtask

   // Advance the model using the inputs in force at the coming edge, then cross it.
   task automatic finish_cycle();
      bit do_push, do_pop;
      if (!resetn || flush) begin
         mq.delete();
      end else begin
         do_push = in_valid && (mq.size() != DEPTH);
         do_pop  = out_allow && (mq.size() != 0);
         if (do_pop)  void'(mq.pop_front());
         if (do_push) mq.push_back(in_bus);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] p0, f[5], wp[10], fp;
      int sent, rcvd;

      resetn = 1'b0; in_valid = 1'b0; in_bus = '0; out_allow = 1'b0; flush = 1'b0;

      p0 = pkt(32'h1c000000, 32'h02800400);
      for (int i = 0; i < 5; i++) f[i] = pkt(32'h1c000000 + 32'(4 * i), 32'h02800000 + 32'(i));

      // Reset hold, first-packet latency, then fill/stall/drain.
      tbl[0]  = mkv(0, 1, 64'hdead_beef_0000_0001, 0, 0, 0, 0, 0, 1, 64'd0);
      tbl[1]  = mkv(0, 1, 64'hdead_beef_0000_0002, 0, 0, 0, 0, 0, 1, 64'd0);
      tbl[2]  = mkv(0, 1, 64'hdead_beef_0000_0003, 0, 0, 0, 0, 0, 1, 64'd0);
      tbl[3]  = mkv(1, 1, p0,    1, 0, 1, 0, 0, 1, 64'd0);
      tbl[4]  = mkv(1, 0, 64'd0, 1, 0, 1, 1, 1, 1, p0);
      tbl[5]  = mkv(1, 0, 64'd0, 0, 0, 1, 0, 0, 0, 64'd0);
      tbl[6]  = mkv(1, 1, f[0],  0, 0, 1, 0, 0, 0, 64'd0);
      tbl[7]  = mkv(1, 1, f[1],  0, 0, 1, 1, 1, 1, f[0]);
      tbl[8]  = mkv(1, 1, f[2],  0, 0, 1, 1, 2, 1, f[0]);
      tbl[9]  = mkv(1, 1, f[3],  0, 0, 1, 1, 3, 1, f[0]);
      tbl[10] = mkv(1, 1, f[4],  0, 0, 0, 1, 4, 1, f[0]);
      tbl[11] = mkv(1, 1, f[4],  1, 0, 0, 1, 4, 1, f[0]);
      tbl[12] = mkv(1, 1, f[4],  1, 0, 1, 1, 3, 1, f[1]);
      tbl[13] = mkv(1, 0, 64'd0, 1, 0, 1, 1, 3, 1, f[2]);
      tbl[14] = mkv(1, 0, 64'd0, 1, 0, 1, 1, 2, 1, f[3]);
      tbl[15] = mkv(1, 0, 64'd0, 1, 0, 1, 1, 1, 1, f[4]);
      tbl[16] = mkv(1, 0, 64'd0, 0, 0, 1, 0, 0, 0, 64'd0);

      for (int i = 0; i < 17; i++) begin
         apply(tbl[i].rstn, tbl[i].iv, tbl[i].bus, tbl[i].oa, tbl[i].fl);
         check($sformatf("tbl%0d_allow", i), {63'd0, in_allow},  {63'd0, tbl[i].e_allow});
         check($sformatf("tbl%0d_ovalid", i), {63'd0, out_valid}, {63'd0, tbl[i].e_ovalid});
         check($sformatf("tbl%0d_count", i), {61'd0, count},     {61'd0, tbl[i].e_count});
         if (tbl[i].chk_bus) check($sformatf("tbl%0d_bus", i), out_bus, tbl[i].e_bus);
         model_check();
         finish_cycle();
      end

      // Wrap: 10 sequential packets, decode allow toggling every cycle.
      for (int i = 0; i < 10; i++) wp[i] = pkt(32'h1c000000 + 32'(4 * i), 32'h00100000 + 32'(i));
      sent = 0; rcvd = 0;
      for (int c = 0; c < 200 && rcvd < 10; c++) begin
         apply(1, sent < 10, wp[sent < 10 ? sent : 9], (c % 2) == 0, 0);
         model_check();
         if (out_valid && out_allow && rcvd < 10) begin
            check($sformatf("wrap_order%0d", rcvd), out_bus, wp[rcvd]);
            rcvd++;
         end
         if (in_valid && m_allow) sent++;
         finish_cycle();
      end
      check("wrap_received", 64'(rcvd), 64'd10);

      // Flush with three entries plus simultaneous push and pop.
      for (int i = 0; i < 3; i++) begin
         apply(1, 1, pkt(32'h1c000040 + 32'(4 * i), 32'h0), 0, 0);
         model_check();
         finish_cycle();
      end
      apply(1, 1, pkt(32'h1c00004c, 32'h0), 1, 1);
      check("flush_pre_count", {61'd0, count}, 64'd3);
      model_check();
      finish_cycle();
      fp = pkt(32'h1c000100, 32'h02800100);
      apply(1, 1, fp, 0, 0);
      check("flush_count",  {61'd0, count},     64'd0);
      check("flush_ovalid", {63'd0, out_valid}, 64'd0);
      check("flush_allow",  {63'd0, in_allow},  64'd1);
      model_check();
      finish_cycle();
      apply(1, 0, 64'd0, 1, 0);
      check("flush_next_bus",    out_bus,           fp);
      check("flush_next_ovalid", {63'd0, out_valid}, 64'd1);
      model_check();
      finish_cycle();

      // Steady state: push and pop together at occupancy 2.
      for (int i = 0; i < 2; i++) begin
         apply(1, 1, pkt(32'h1c000200 + 32'(4 * i), 32'h13), 0, 0);
         model_check();
         finish_cycle();
      end
      for (int i = 0; i < 8; i++) begin
         apply(1, 1, pkt(32'h1c000208 + 32'(4 * i), 32'h13), 1, 0);
         check($sformatf("steady_count%0d", i), {61'd0, count}, 64'd2);
         model_check();
         finish_cycle();
      end

      // Random traffic including occasional flush and mid-stream reset.
      for (int i = 0; i < 400; i++) begin
         apply(($urandom_range(63) != 0), $urandom_range(1), {$urandom, $urandom},
               $urandom_range(1), ($urandom_range(15) == 0));
         model_check();
         finish_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_if_id_inst_queue

// File: doc/if_id_inst_queue.md
# if_id_inst_queue

Instruction queue between the fetch stage and the decode stage. It captures each `{pc, inst}` fetch packet in a small FIFO, so a decode stall never loses the instruction SRAM read data, and fetch keeps running until the queue is full. It presents the oldest packet to decode with a valid/allow handshake and drops all contents on a pipeline flush.

## Interface
Parameters:
- `DEPTH`, 4, number of entries; power of two, ≥2.
- `BUS_W`, `` `IF_to_ID_Bus_Size `` (64), packet width, `{pc[31:0], inst[31:0]}`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  fetch packet valid (fetch-stage `IF_to_ID_Valid`).
- `in_bus`  in  BUS_W  fetch packet.
- `in_allow`  out  1  queue accepts a packet this cycle; drives fetch-stage `ID_Allow_in`.
- `out_valid`  out  1  head packet valid toward decode.
- `out_bus`  out  BUS_W  head packet.
- `out_allow`  in  1  decode consumes the head this cycle.
- `flush`  in  1  `excp_flush | ertn_flush | br_taken`; discards the queue.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries (debug/perf).

## Operation
- Storage: `DEPTH` × `BUS_W` register array, write pointer `wr_ptr`, read pointer `rd_ptr`, occupancy `count`.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally modulo DEPTH.
- push = `in_valid & in_allow & ~flush`.
  - Writes `in_bus` at `wr_ptr`.
  - `wr_ptr` increments.
- pop = `out_valid & out_allow & ~flush`.
  - `rd_ptr` increments.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop in the same cycle.
- `in_allow` = `(count != DEPTH) & resetn`.
  - Depends only on registered state; there is no combinational path from `out_allow`.
  - When full, a same-cycle pop does not open a slot until the next cycle.
- `out_valid` = `count != 0`.
- `out_bus` = `mem[rd_ptr]`, read combinationally from the register array.
- Flush (highest priority):
  - Next state: `wr_ptr = rd_ptr = 0`, `count = 0`.
  - Any push or pop in the flush cycle is ignored.
  - The redirected fetch packet arrives at the earliest on the following cycle and is accepted normally.
- Reset (`resetn` low at the edge):
  - `wr_ptr = rd_ptr = 0`, `count = 0`, all entries = 0.
  - Takes priority over flush and over any handshake.
  - Reset mid-operation discards all contents identically.
- Packets are never reordered, duplicated or modified.
- `pc` travels with its `inst` unchanged.

## Timing
- Latency: a packet pushed at edge N is presented at `out_valid/out_bus` after edge N, i.e. in cycle N+1 when the queue was empty. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained at any occupancy < DEPTH.
- Values during and after reset:
  - `in_allow` = 0 while `resetn` is low.
  - `out_valid` = 0, `out_bus` = 0, `count` = 0.
  - First cycle after reset: `in_allow` = 1.
- Full boundary: `count == DEPTH` → `in_allow = 0`. Fetch holds its PC and packet; the upstream hold already keys on `ID_Allow_in`.
- Empty boundary: `count == 0` → `out_valid = 0`. `out_bus` shows the stale slot and must be ignored.
- Wrap: pointer rollover from DEPTH−1 to 0 requires no special handling.
- Flush with full queue and simultaneous push/pop: the result is empty and `in_allow = 1` next cycle.

## Structure
- `` `IF_to_ID_Bus_Size `` comes from the shared header `my_cpu.vh`, and so does the new constant `` `IQ_DEPTH `` (4), used to set `DEPTH` at instantiation.
- Single module, with no sub-module. Pointer/count logic and the storage array are under ~150 lines.
- Top-level wiring:
  - Instantiated between the fetch and decode units.
  - `in_allow` replaces the decode `ID_Allow_in` formerly fed to fetch.
  - `out_allow` is the decode stage's allow-in.

## Test plan
- **Reset:** hold `resetn` = 0 for 3 cycles with `in_valid` = 1 → `in_allow` = 0, `out_valid` = 0, `count` = 0 throughout. First cycle after release: `in_allow` = 1.
- **Latency:** push `{0x1c000000, 0x02800400}` into an empty queue with `out_allow` = 1 → `out_valid` = 1 with that exact bus one cycle later, then `count` returns to 0.
- **Fill and stall:** `out_allow` = 0, push PCs 0x1c000000..0x1c00000c → `count` = 4 and `in_allow` = 0. A 5th packet is held, not written. Release `out_allow` → packets emerge in PC order, then the 5th.
- **Wrap:** stream 10 sequential packets with `out_allow` toggling 1,0,1,0 → output order is exactly PCs +0..+0x24 with no loss or duplication.
- **Flush:** queue holding 3 entries, assert `flush` together with push and pop → next cycle `count` = 0, `out_valid` = 0. The packet pushed on the following cycle (PC 0x1c000100) appears next.
- **Steady state:** simultaneous push/pop at `count` = 2 for 8 cycles → `count` stays 2 and ordering is preserved.
